// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of a sampled PWM input and reports
// the duty cycle in percent, with timeout detection of a constant input.
module pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [7:0]       duty_val,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             stuck,
  output logic             ovr
);

  localparam int unsigned DW = CNT_W + 8;
  localparam logic [CNT_W-1:0] IdleMax = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StMeas, StDiv} state_e;

  state_e           state_q;
  logic             sync1_q, sync2_q, sync3_q;
  logic [CNT_W-1:0] per_c_q, hi_c_q, idle_c_q;
  logic [CNT_W-1:0] p_q, h_q;
  logic [DW-1:0]    rem_q, den_q;
  logic [7:0]       quo_q;
  logic [2:0]       bit_q;

  logic             rise;
  logic             timeout_hit;
  logic             rem_ge;
  logic [DW-1:0]    rem_sub;
  logic [DW-1:0]    dividend;
  logic [7:0]       quo_next;

  assign rise        = sync2_q & ~sync3_q;
  // idle_c saturates at TIMEOUT-1 so a timeout masked by DIV fires right after it
  assign timeout_hit = (idle_c_q >= IdleMax) && (state_q != StDiv) && !rise;
  assign dividend    = DW'(hi_c_q) * DW'(100);
  assign rem_ge      = (rem_q >= den_q);
  assign rem_sub     = rem_q - den_q;
  assign quo_next    = {quo_q[6:0], rem_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      per_c_q    <= '0;
      hi_c_q     <= '0;
      idle_c_q   <= '0;
      p_q        <= '0;
      h_q        <= '0;
      rem_q      <= '0;
      den_q      <= '0;
      quo_q      <= '0;
      bit_q      <= '0;
      duty_val   <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      valid   <= 1'b0;

      if (rise) begin
        per_c_q  <= CNT_W'(1);
        hi_c_q   <= CNT_W'(1);
        idle_c_q <= '0;
      end else begin
        per_c_q <= per_c_q + CNT_W'(1);
        if (sync2_q) hi_c_q <= hi_c_q + CNT_W'(1);
        if (timeout_hit) idle_c_q <= '0;
        else if (idle_c_q < IdleMax) idle_c_q <= idle_c_q + CNT_W'(1);
      end

      unique case (state_q)
        StIdle, StMeas: begin
          if (rise) begin
            if (state_q == StMeas) begin
              p_q     <= per_c_q;
              h_q     <= hi_c_q;
              rem_q   <= dividend;
              den_q   <= DW'(per_c_q) << 7;
              quo_q   <= '0;
              bit_q   <= '0;
              state_q <= StDiv;
            end else begin
              state_q <= StMeas;
            end
          end else if (timeout_hit) begin
            valid      <= 1'b1;
            stuck      <= 1'b1;
            high_cnt   <= '0;
            period_cnt <= '0;
            duty_val   <= sync2_q ? 8'd100 : 8'd0;
            state_q    <= StIdle;
          end
        end
        StDiv: begin
          if (rise) ovr <= 1'b1;
          if (rem_ge) rem_q <= rem_sub;
          den_q <= den_q >> 1;
          quo_q <= quo_next;
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            duty_val   <= quo_next;
            high_cnt   <= h_q;
            period_cnt <= p_q;
            stuck      <= 1'b0;
            valid      <= 1'b1;
            state_q    <= StMeas;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
